multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Moore-style main FSM plus ALU decoder that sequences the multicycle RV32I datapath: register file, Extend, the three-input Multiplex instances, ALU, and the loadRegs pipeline registers. It issues every enable and mux select each cycle from the instruction held in the instruction register, and raises a sticky fault flag on unsupported opcodes.

Parameters:
ALUCTRL_W, 3, width of ALUControl bus
STATE_W, 4, width of state register and state_dbg

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  7  instruction[6:0] from the instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
zero  input  1  ALU Zero flag
PCWrite  output  1  PC register load
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut/Result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  loads OldPC and Instruction registers
ResultSrc  output  2  00=ALUResult, 01=Data, 10=ALUOut
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1 register
ALUSrcB  output  2  00=RD2 register, 01=ImmExt, 10=constant 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
ALUControl  output  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  output  1  register file WE3
illegal  output  1  sticky: unsupported opcode decoded
state_dbg  output  STATE_W  current state code

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high: state=FETCH, illegal=0, and PCWrite, MemWrite, IRWrite and RegWrite are all forced to 0. FETCH outputs apply from the first rising edge after reset falls.
- Output decode: all outputs are a combinational decode of the state register (Moore), with one exception: PCWrite = PCUpdate | (Branch & zero).
- States and outputs. Any select or enable not listed is 0 or don't-care.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=00, PCUpdate=1. Next state DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp add, so the branch/jump target is computed into ALUOut. ImmSrc follows op.
  - DECODE next state by op: 0000011 or 0100011 to MEMADR; 0110011 to EXECUTER; 0010011 to EXECUTEI; 1101111 to JAL; 1100011 to BEQ; any other op to ILLEGAL.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next MEMREAD for load, MEMWRITE for store.
  - MEMREAD: ResultSrc=10, AdrSrc=1. Next MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE: ResultSrc=10, AdrSrc=1, MemWrite=1. Next FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp funct. Next ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp funct. Next ALUWB.
  - ALUWB: ResultSrc=10, RegWrite=1. Next FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=10, Branch=1. Next FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1. Next ALUWB.
  - ILLEGAL: all write enables 0, illegal=1. Holds until reset.
- ALU decode:
  - ALUOp add gives 000; ALUOp sub gives 001.
  - ALUOp funct decodes funct3: 000 is sub if {op[5],funct7b5}=11, otherwise add; 010 gives 101; 110 gives 011; 111 gives 010.
  - Any other funct3 gives 000, with no fault raised.
- Latency in cycles: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.
- Inputs op/funct3/funct7b5 are sampled only in DECODE and later states. They are stable because IRWrite is asserted only in FETCH.
- Reset mid-instruction: the FSM aborts immediately. No partial writeback occurs because the write enables are gated by reset.
- zero is ignored in every state except BEQ.

Decomposition:
- Package riscv_ctrl_pkg holds: the state enumeration codes, the opcode constants, the ALUControl codes, the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc select encodings, and the ALUOp codes. The datapath mux instances and ALU use the same package.
- Sub-module alu_decoder is purely combinational: (ALUOp, funct3, op[5], funct7b5) to ALUControl.
- The FSM stays in the top module.

Test Plan:
- Reset release with op=0110011, funct3=000, funct7b5=1: FETCH then DECODE then EXECUTER (ALUControl=001) then ALUWB (RegWrite=1) then FETCH. Four cycles; IRWrite=1 only in cycle 1.
- lw (op=0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. MEMWB has ResultSrc=01 and RegWrite=1; MEMWRITE is never visited; MemWrite stays 0.
- beq with zero=1: PCWrite=1 in the BEQ cycle with ALUControl=001. Repeat with zero=0: PCWrite=0. Both return to FETCH after 3 cycles.
- jal: JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10. The next state ALUWB has RegWrite=1.
- op=1111111: state goes to ILLEGAL, illegal=1, and it holds for 10 or more cycles with all enables 0. Asserting reset clears illegal and returns state to FETCH.
- sw with reset asserted asynchronously mid-cycle during MEMWRITE: MemWrite drops to 0 immediately and state_dbg shows the FETCH code before the next edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath (muxes, ALU).
// Pure definitions: no latency, no flow control.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and instruction fields.
// Combinational, zero latency, no flow control; unknown funct3 falls back to add silently.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type from I-type: addi never subtracts
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore main FSM sequencing the multicycle RV32I datapath; lw 5, sw/R/I/jal 4, beq 3 cycles.
// No backpressure; write enables are gated by reset so an aborted instruction never commits.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state_dbg
);

    state_t     state, state_next;
    aluop_t     alu_op;
    logic       pc_update, branch;
    logic       mem_write_raw, ir_write_raw, reg_write_raw;
    logic [2:0] alu_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALU;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                pc_update    = 1'b1;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                // branch/jump target lands in ALUOut while the class is resolved
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BEQ:            state_next = S_BEQ;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ResultSrc  = RES_ALUOUT;
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                ResultSrc     = RES_ALUOUT;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                ResultSrc  = RES_ALUOUT;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALUOut while ALU forms the link address OldPC+4
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = IMM_S;
            OP_BEQ:   ImmSrc = IMM_B;
            OP_JAL:   ImmSrc = IMM_J;
            default:  ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl)
    );

    assign PCWrite    = ~reset & (pc_update | (branch & zero));
    assign MemWrite   = ~reset & mem_write_raw;
    assign IRWrite    = ~reset & ir_write_raw;
    assign RegWrite   = ~reset & reg_write_raw;
    assign ALUControl = ALUCTRL_W'(alu_ctrl);
    assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded random bench for multicycle_control_unit: per-cycle expectations are queued by the driver.
module tb_multicycle_control_unit;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    multicycle_control_unit #(.ALUCTRL_W(3), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        logic       rw, ill;
        logic [3:0] st;
    } outv_t;

    typedef struct {
        outv_t v;
        outv_t m;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // A negative select argument means "don't care" for that cycle.
    function automatic exp_t mk(string tag, logic [3:0] st, bit pcw, bit mw, bit irw, bit rw, bit ill,
                                int adr, int rs, int sa, int sb_, int imm, int ac);
        exp_t e;
        e.tag = tag;
        e.v = '0; e.m = '0;
        e.v.st = st;  e.m.st = '1;
        e.v.pcw = pcw; e.m.pcw = 1'b1;
        e.v.mw = mw;   e.m.mw = 1'b1;
        e.v.irw = irw; e.m.irw = 1'b1;
        e.v.rw = rw;   e.m.rw = 1'b1;
        e.v.ill = ill; e.m.ill = 1'b1;
        if (adr >= 0) begin e.v.adr = adr[0];   e.m.adr = 1'b1; end
        if (rs  >= 0) begin e.v.rs  = rs[1:0];  e.m.rs  = '1;   end
        if (sa  >= 0) begin e.v.sa  = sa[1:0];  e.m.sa  = '1;   end
        if (sb_ >= 0) begin e.v.sb  = sb_[1:0]; e.m.sb  = '1;   end
        if (imm >= 0) begin e.v.imm = imm[1:0]; e.m.imm = '1;   end
        if (ac  >= 0) begin e.v.ac  = ac[2:0];  e.m.ac  = '1;   end
        return e;
    endfunction

    function automatic int alu_funct(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int imm_for(logic [6:0] o);
        case (o)
            7'b0100011:             return 1;
            7'b1100011:             return 2;
            7'b1101111:             return 3;
            7'b0000011, 7'b0010011: return 0;
            default:                return -1;
        endcase
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_zero(int zs);
        zero = (zs == 2) ? 1'($urandom_range(1, 0)) : (zs == 1);
    endtask

    task automatic cycle(exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(mk("RESET", S_FETCH, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1));
        reset = 1'b0;
    endtask

    // Reference sequence of one instruction; zs: 0/1 forces zero, 2 randomises it every cycle.
    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, int zs, int ill_cycles);
        op = o; funct3 = f3; funct7b5 = f7;
        set_zero(zs);
        cycle(mk("FETCH", S_FETCH, 1, 0, 1, 0, 0, 0, 0, 0, 2, -1, 0));
        set_zero(zs);
        cycle(mk("DECODE", S_DECODE, 0, 0, 0, 0, 0, -1, -1, 1, 1, imm_for(o), 0));
        set_zero(zs);
        case (o)
            7'b0000011: begin
                cycle(mk("MEMADR", S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0, 0));
                set_zero(zs);
                cycle(mk("MEMREAD", S_MEMREAD, 0, 0, 0, 0, 0, 1, 2, -1, -1, -1, -1));
                set_zero(zs);
                cycle(mk("MEMWB", S_MEMWB, 0, 0, 0, 1, 0, -1, 1, -1, -1, -1, -1));
            end
            7'b0100011: begin
                cycle(mk("MEMADR", S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 1, 0));
                set_zero(zs);
                cycle(mk("MEMWRITE", S_MEMWRITE, 0, 1, 0, 0, 0, 1, 2, -1, -1, -1, -1));
            end
            7'b0110011, 7'b0010011: begin
                if (o[5]) cycle(mk("EXECUTER", S_EXECUTER, 0, 0, 0, 0, 0, -1, -1, 2, 0, -1, alu_funct(o, f3, f7)));
                else      cycle(mk("EXECUTEI", S_EXECUTEI, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0, alu_funct(o, f3, f7)));
                set_zero(zs);
                cycle(mk("ALUWB", S_ALUWB, 0, 0, 0, 1, 0, -1, 2, -1, -1, -1, -1));
            end
            7'b1100011:
                cycle(mk("BEQ", S_BEQ, zero, 0, 0, 0, 0, -1, 2, 2, 0, -1, 1));
            7'b1101111: begin
                cycle(mk("JAL", S_JAL, 1, 0, 0, 0, 0, -1, 2, 1, 2, -1, 0));
                set_zero(zs);
                cycle(mk("ALUWB", S_ALUWB, 0, 0, 0, 1, 0, -1, 2, -1, -1, -1, -1));
            end
            default: begin
                for (int i = 0; i < ill_cycles; i++) begin
                    cycle(mk("ILLEGAL", S_ILLEGAL, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1));
                    set_zero(zs);
                end
            end
        endcase
    endtask

    initial begin : monitor
        exp_t  e;
        outv_t got, diff;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rs: ResultSrc,
                        sa: ALUSrcA, sb: ALUSrcB, imm: ImmSrc, ac: ALUControl, rw: RegWrite,
                        ill: illegal, st: state_dbg};
                diff = (got ^ e.v) & e.m;
                tests++;
                if (diff != '0) begin
                    fails++;
                    $display("FAIL %s: got %h, expected %h under mask %h at %0t", e.tag, got, e.v, e.m, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [6:0] ops [6];
        logic [6:0] o;
        int         k;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(7'b0110011, 3'b000, 1'b1, 2, 0);
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 0);
        run_instr(7'b0100011, 3'b010, 1'b0, 2, 0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1, 0);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);
        run_instr(7'b1101111, 3'b000, 1'b0, 2, 0);
        run_instr(7'b0010011, 3'b000, 1'b1, 2, 0);
        run_instr(7'b0110011, 3'b001, 1'b1, 2, 0);
        run_instr(7'b0110011, 3'b111, 1'b0, 2, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(5, 0);
            run_instr(ops[k], 3'($urandom), 1'($urandom), 2, 0);
        end

        // store aborted by an asynchronous reset in the middle of its MEMWRITE cycle
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        cycle(mk("FETCH", S_FETCH, 1, 0, 1, 0, 0, 0, 0, 0, 2, -1, 0));
        cycle(mk("DECODE", S_DECODE, 0, 0, 0, 0, 0, -1, -1, 1, 1, 1, 0));
        cycle(mk("MEMADR", S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 1, 0));
        sb.push_back(mk("MEMWRITE", S_MEMWRITE, 0, 1, 0, 0, 0, 1, 2, -1, -1, -1, -1));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_memwrite", int'(MemWrite), 0);
        chk("midrst_state", int'(state_dbg), int'(S_FETCH));
        chk("midrst_pcwrite", int'(PCWrite), 0);
        chk("midrst_irwrite", int'(IRWrite), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(7'b0110011, 3'b110, 1'b0, 2, 0);

        run_instr(7'b1111111, 3'b000, 1'b0, 2, 12);
        do_reset();
        o = 7'b1111111;
        for (int t = 0; t < 50 && is_legal(o) || o == 7'b1111111; t++) o = 7'($urandom);
        run_instr(o, 3'($urandom), 1'($urandom), 2, 11);
        do_reset();
        run_instr(7'b1101111, 3'b000, 1'b0, 2, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
